rr_merge2: RTL

Two-input round-robin stream merger: arbitrates between stream A and stream B with valid/ready handshakes and forwards granted beats through a one-entry output register. Sits directly upstream of the 2:1 mux datapath. It owns the `sel` decision (0 = A, 1 = B, same convention as `y = sel ? b : a`) and exports `sel` so a downstream mux or tracer can follow the grant.

---
 rtl/rr_merge2.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rr_merge2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_merge2
//  Purpose  : Two-input round-robin stream merger. Arbitrates between stream
//             A and stream B (valid/ready) with a per-grant burst limit and
//             forwards granted beats through a one-entry output register.
//             Exports the current grant as sel (0 = A, 1 = B).
//  Ports    : clk, rst (async, active-high)
//             a_data/a_valid/a_ready : stream A input
//             b_data/b_valid/b_ready : stream B input
//             y_data/y_valid/y_ready : merged output (registered)
//             sel                    : current grant, registered
//  Revision : 1.0  initial release
// ============================================================================
module rr_merge2 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [7:0] C_MAX  = 8'(MAX_BURST);
  localparam logic       C_SIDE_A = 1'b0;
  localparam logic       C_SIDE_B = 1'b1;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_valid_q, y_valid_d;

  logic             w_slot_ready;
  logic             w_fire_a;
  logic             w_fire_b;
  logic             w_fire;
  logic [8:0]       w_cnt_sum;
  logic [7:0]       w_cnt_next;
  logic             w_burst_done;

  // The output slot can take a new beat while the current one drains.
  assign w_slot_ready = ~y_valid_q | y_ready;

  assign a_ready  = (state_q == GRANT_A) & w_slot_ready;
  assign b_ready  = (state_q == GRANT_B) & w_slot_ready;
  assign w_fire_a = a_valid & a_ready;
  assign w_fire_b = b_valid & b_ready;
  assign w_fire   = w_fire_a | w_fire_b;

  // Saturating beat counter; once at the limit it stays there so a late
  // competitor is granted on the very next edge.
  assign w_cnt_sum    = {1'b0, cnt_q} + {8'd0, w_fire};
  assign w_cnt_next   = (w_cnt_sum >= {1'b0, C_MAX}) ? C_MAX : w_cnt_sum[7:0];
  assign w_burst_done = (w_cnt_next == C_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;

    // Output register
    if (w_fire_a) begin
      y_data_d  = a_data;
      y_valid_d = 1'b1;
    end else if (w_fire_b) begin
      y_data_d  = b_data;
      y_valid_d = 1'b1;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end

    // Grant control
    case (state_q)
      IDLE: begin
        if (a_valid & b_valid) begin
          // Contention from idle goes to the side that was not served last.
          if (last_q == C_SIDE_B) begin
            state_d = GRANT_A;
            last_d  = C_SIDE_A;
          end else begin
            state_d = GRANT_B;
            last_d  = C_SIDE_B;
          end
          cnt_d = 8'd0;
        end else if (a_valid) begin
          state_d = GRANT_A;
          last_d  = C_SIDE_A;
          cnt_d   = 8'd0;
        end else if (b_valid) begin
          state_d = GRANT_B;
          last_d  = C_SIDE_B;
          cnt_d   = 8'd0;
        end
      end

      GRANT_A: begin
        if (b_valid & (w_burst_done | ~a_valid)) begin
          state_d = GRANT_B;
          last_d  = C_SIDE_B;
          cnt_d   = 8'd0;
        end else if (~a_valid) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = w_cnt_next;
        end
      end

      GRANT_B: begin
        if (a_valid & (w_burst_done | ~b_valid)) begin
          state_d = GRANT_A;
          last_d  = C_SIDE_A;
          cnt_d   = 8'd0;
        end else if (~b_valid) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = w_cnt_next;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      last_q    <= C_SIDE_B;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign sel     = (state_q == GRANT_B);

endmodule
`default_nettype wire
